rc5_key_expand: RTL and testbench
=================================

Name: rc5_key_expand

Overview:
- RC5-32/12/16 key schedule: expands a 128-bit user key into the 26-word round-key table skey[0:25].
- Sits directly upstream of the encrypt and decrypt blocks and replaces their hardcoded skey constant.
- Iterative datapath with one mixing step per clock, so the table is stored in registers.

Parameters:
- ROUNDS, 12, number of RC5 rounds; T = 2*(ROUNDS+1) = 26 table words.
- KEY_WORDS, 4, 32-bit words in the user key (C); key width = 32*KEY_WORDS.
- Derived constant MIX_ITERS = 3*max(T, KEY_WORDS) = 78. It is not overridable.

Ports:
- clk  input  1  the single clock; all state changes on posedge.
- clr  input  1  synchronous reset, active-high; sampled on posedge clk.
- key_in  input  128  user key; L[j] = key_in[32j+31:32j], so byte k = key_in[8k+7:8k].
- key_vld  input  1  request expansion of key_in; key_in is sampled only on the accepting edge.
- busy  output  1  high during ST_INIT and ST_MIX.
- key_rdy  output  1  high in ST_READY; skey_flat is valid and stable.
- skey_flat  output  832  skey[i] = skey_flat[32i+31:32i], i = 0..25.

Behaviour:
- Reset: clr=1 at posedge has the following effects.
  - State goes to ST_IDLE.
  - busy=0, key_rdy=0.
  - skey_flat, L[0:3], A, B and all counters are cleared to 0.
  - clr has priority over every other input, including a simultaneous key_vld.
- ST_IDLE: on key_vld=1, load L[0:3] from key_in, set the init accumulator to P32=0xB7E15163, set i=0, and go to ST_INIT.
- ST_INIT: runs for 26 edges.
  - Each edge writes S[i] = acc, then acc = acc + Q32 (Q32 = 0x9E3779B9, mod 2^32), then i++.
  - After the write of S[25]: clear A, B, i and j, load the 7-bit mix counter with 0, and go to ST_MIX.
- ST_MIX: runs for 78 edges, one iteration per edge. Steps 3 and 4 use the A from step 2 of the same edge.
  1. A' = (S[i] + A + B) <<< 3
  2. S[i] = A'
  3. B' = (L[j] + A' + B) <<< ((A' + B) & 31)
  4. L[j] = B'
  5. i = (i==25) ? 0 : i+1; j = (j+1) mod 4 (2-bit wrap).
  6. All additions are mod 2^32; a rotate by 0 returns its input unchanged (no shift-by-32).
  7. After iteration 77 (counter==77), go to ST_READY.
- ST_READY: key_rdy=1 and skey_flat holds S.
  - key_vld=1 restarts exactly as in ST_IDLE; key_rdy drops on that same edge.
- Latency: key_rdy rises on the 105th posedge counting the accepting edge as 1 (1 + 26 + 78).
- key_vld while busy=1 is ignored; key_in changes during busy have no effect.
- clr mid-INIT or mid-MIX aborts to ST_IDLE with the reset values above; there is no partial table output.
- skey_flat is driven directly from the S register array. During busy it changes and must not be used; consumers gate on key_rdy.
- The state encoding is four states; an illegal encoding returns to ST_IDLE on the next edge.

Decomposition:
- rc5_pkg holds the following:
  - constants P32, Q32, T, C and MIX_ITERS;
  - the state enum ST_IDLE/ST_INIT/ST_MIX/ST_READY;
  - the word-index function for skey_flat slicing.
- Sub-module rc5_rotl is natural: a combinational 32-bit rotate-left by a 5-bit amount. It is instantiated twice here and reused by encrypt.

Test Plan:
- Reset values: hold clr=1 for 3 cycles, then release → busy=0, key_rdy=0, skey_flat=0, and the outputs stay idle with key_vld=0.
- Init check: key_vld=1 with key_in=0, then stop the bench at the ST_INIT→ST_MIX transition.
  - Required: S[0]=0xB7E15163, S[1]=0x5618CB1C, S[25]=0xB7E15163+25*Q32 mod 2^32.
- Known answer: expand key_in=0 → key_rdy on edge 105, and skey_flat matches the behavioural model word for word.
  - Feed skey into encrypt with din=0 → dout=0xEEDBA521_6D8F4B15.
- Busy protection: during ST_MIX, pulse key_vld with key_in=0x915F4619BE41B2516355A50110A9CE91 → ignored; the table still equals the key=0 result.
- Restart from READY: apply key_vld with key_in=0x915F4619BE41B2516355A50110A9CE91.
  - key_rdy falls on the next edge and busy rises.
  - The new table is ready 105 edges later.
  - Encrypt with din=0x21A5DBEE154B8F6D (byte order) → ciphertext bytes F7C013AC5B2B8952.
- Abort/priority: assert clr at mix iteration 40 → ST_IDLE, skey_flat=0, key_rdy=0.
  - Then assert clr=1 and key_vld=1 on the same edge → remains ST_IDLE.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5-32/12/16 constants, controller state type and round-key word slicing helper.
package rc5_pkg;

    localparam int ROUNDS    = 12;
    localparam int KEY_WORDS = 4;
    localparam int T         = 2 * (ROUNDS + 1);
    localparam int C         = KEY_WORDS;
    localparam int MIX_ITERS = 3 * ((T > C) ? T : C);

    localparam int IDX_W = $clog2(T);
    localparam int CNT_W = $clog2(MIX_ITERS);

    localparam logic [31:0] P32 = 32'hB7E1_5163;
    localparam logic [31:0] Q32 = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_MIX   = 2'd2,
        ST_READY = 2'd3
    } state_e;

    // Bit offset of round-key word idx inside the flattened table.
    function automatic int unsigned word_lsb(input int unsigned idx);
        return 32 * idx;
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// Combinational 32-bit rotate-left by a 5-bit amount; amount 0 passes the input through.
module rc5_rotl (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);

    // A right shift by 32 yields zero, so amt == 0 collapses to din without a special case.
    assign dout = (din << amt) | (din >> (6'd32 - {1'b0, amt}));

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-32/12/16 key schedule: one table-init word or one mixing step per clock,
// with the 26-word round-key table held in registers and exposed flat.
module rc5_key_expand
    import rc5_pkg::*;
(
    input  logic         clk,
    input  logic         clr,
    input  logic [127:0] key_in,
    input  logic         key_vld,
    output logic         busy,
    output logic         key_rdy,
    output logic [831:0] skey_flat
);

    state_e             state_q, state_d;
    logic [31:0]        s_q [T];
    logic [31:0]        s_d [T];
    logic [31:0]        l_q [C];
    logic [31:0]        l_d [C];
    logic [31:0]        a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [1:0]         j_q, j_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        sum_a, a_new, ab_sum, sum_b, b_new;

    // The B half of a mixing step depends on the freshly rotated A of the same step.
    assign sum_a  = s_q[i_q] + a_q + b_q;
    assign ab_sum = a_new + b_q;
    assign sum_b  = l_q[j_q] + ab_sum;

    rc5_rotl u_rotl_a (
        .din  (sum_a),
        .amt  (5'd3),
        .dout (a_new)
    );

    rc5_rotl u_rotl_b (
        .din  (sum_b),
        .amt  (ab_sum[4:0]),
        .dout (b_new)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        l_d     = l_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (key_vld) begin
                    for (int c = 0; c < C; c++) begin
                        l_d[c] = key_in[32*c +: 32];
                    end
                    acc_d   = P32;
                    i_d     = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                s_d[i_q] = acc_q;
                acc_d    = acc_q + Q32;
                if (i_q == IDX_W'(T - 1)) begin
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_MIX;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_MIX: begin
                s_d[i_q] = a_new;
                l_d[j_q] = b_new;
                a_d      = a_new;
                b_d      = b_new;
                i_d      = (i_q == IDX_W'(T - 1)) ? '0 : i_q + 1'b1;
                j_d      = j_q + 2'd1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MIX_ITERS - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            for (int k = 0; k < T; k++) begin
                s_q[k] <= '0;
            end
            for (int k = 0; k < C; k++) begin
                l_q[k] <= '0;
            end
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            l_q     <= l_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q == ST_INIT) || (state_q == ST_MIX);
    assign key_rdy = (state_q == ST_READY);

    for (genvar gi = 0; gi < T; gi++) begin : g_flat
        assign skey_flat[word_lsb(gi) +: 32] = s_q[gi];
    end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for the RC5 key schedule: reset, init table, known-answer
// ciphertexts, busy protection, restart from ready and clr abort/priority.
module tb_rc5_key_expand;

    logic         clk;
    logic         clr;
    logic [127:0] key_in;
    logic         key_vld;
    logic         busy;
    logic         key_rdy;
    logic [831:0] skey_flat;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_s [26];

    // Key bytes 91 5F 46 19 BE 41 B2 51 63 55 A5 01 10 A9 CE 91 with byte 0 in the low bits.
    localparam logic [127:0] KEY2 = 128'h91CEA910_01A55563_51B241BE_19465F91;

    rc5_key_expand dut (
        .clk       (clk),
        .clr       (clr),
        .key_in    (key_in),
        .key_vld   (key_vld),
        .busy      (busy),
        .key_rdy   (key_rdy),
        .skey_flat (skey_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] n);
        logic [4:0] r;
        r = n[4:0];
        if (r == 5'd0) return x;
        return (x << r) | (x >> (6'd32 - {1'b0, r}));
    endfunction

    function automatic logic [31:0] dut_word(input int idx);
        return skey_flat[32*idx +: 32];
    endfunction

    // Textbook RC5 key expansion producing the reference table in m_s.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int c = 0; c < 4; c++) l[c] = key[32*c +: 32];
        m_s[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) m_s[k] = m_s[k-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            a = rotl(m_s[i] + a + b, 32'd3);
            m_s[i] = a;
            b = rotl(l[j] + a + b, a + b);
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    // RC5 encryption using the table currently on skey_flat; {A,B} in and out.
    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [31:0] a, b;
        a = pt[63:32] + dut_word(0);
        b = pt[31:0]  + dut_word(1);
        for (int r = 1; r <= 12; r++) begin
            a = rotl(a ^ b, b) + dut_word(2*r);
            b = rotl(b ^ a, a) + dut_word(2*r + 1);
        end
        return {a, b};
    endfunction

    task automatic chk_table(input string tag);
        for (int k = 0; k < 26; k++) begin
            chk($sformatf("%s_s%0d", tag, k), {32'd0, dut_word(k)}, {32'd0, m_s[k]});
        end
    endtask

    initial begin
        logic [31:0] e25;
        clr = 1'b1; key_vld = 1'b0; key_in = '0;

        // Reset and idle hold
        step(3);
        clr = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rdy", {63'd0, key_rdy}, 64'd0);
        chk("rst_flat_nz", {63'd0, |skey_flat}, 64'd0);
        step(3);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_rdy", {63'd0, key_rdy}, 64'd0);

        // key = 0, stop at INIT->MIX transition (edge 27)
        key_in = '0; key_vld = 1'b1;
        step(1);
        key_vld = 1'b0;
        chk("acc_busy", {63'd0, busy}, 64'd1);
        chk("acc_rdy", {63'd0, key_rdy}, 64'd0);
        step(26);
        e25 = 32'hB7E15163 + 32'd25 * 32'h9E3779B9;
        chk("init_s0", {32'd0, dut_word(0)}, 64'h0000_0000_B7E1_5163);
        chk("init_s1", {32'd0, dut_word(1)}, 64'h0000_0000_5618_CB1C);
        chk("init_s25", {32'd0, dut_word(25)}, {32'd0, e25});

        // Busy protection: pulse key_vld with another key during MIX
        step(10);
        key_in = KEY2; key_vld = 1'b1;
        step(1);
        key_vld = 1'b0; key_in = ~KEY2;
        step(66);
        chk("k0_rdy_e104", {62'd0, busy, key_rdy}, 64'd2);
        step(1);
        chk("k0_rdy_e105", {62'd0, busy, key_rdy}, 64'd1);
        model_expand(128'd0);
        chk_table("k0");
        chk("k0_enc", encrypt(64'd0), 64'hEEDBA521_6D8F4B15);

        // Restart from READY with KEY2; key_in disturbed while busy
        key_in = KEY2; key_vld = 1'b1;
        step(1);
        key_vld = 1'b0; key_in = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        chk("rs_edge1", {62'd0, busy, key_rdy}, 64'd2);
        step(103);
        chk("rs_e104", {62'd0, busy, key_rdy}, 64'd2);
        step(1);
        chk("rs_e105", {62'd0, busy, key_rdy}, 64'd1);
        model_expand(KEY2);
        chk_table("k2");
        chk("k2_enc", encrypt(64'hEEDBA521_6D8F4B15), 64'hAC13C0F7_52892B5B);

        // Abort at mix iteration 40
        key_in = KEY2; key_vld = 1'b1;
        step(1);
        key_vld = 1'b0;
        step(26 + 40);
        chk("ab_busy_pre", {62'd0, busy, key_rdy}, 64'd2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("ab_state", {62'd0, busy, key_rdy}, 64'd0);
        chk("ab_flat_nz", {63'd0, |skey_flat}, 64'd0);

        // clr wins over simultaneous key_vld
        clr = 1'b1; key_vld = 1'b1;
        step(1);
        clr = 1'b0; key_vld = 1'b0;
        chk("pri_state", {62'd0, busy, key_rdy}, 64'd0);
        step(2);
        chk("pri_hold", {62'd0, busy, key_rdy}, 64'd0);
        chk("pri_flat_nz", {63'd0, |skey_flat}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
